// File: rtl/noc_input_buffer.sv
// Credit-based input FIFO for one router input port. Flits arriving from the
// upstream link are queued until the crossbar pops them; every pop returns one
// credit to the upstream sender on the following cycle.
module noc_input_buffer #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       valid_i,
   input  logic [WIDTH-1:0]           data_i,
   output logic                       credit_o,
   output logic                       out_valid,
   output logic [WIDTH-1:0]           out_data,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       overflow_err
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   // Storage is never reset; only the pointers and occupancy define validity.
   logic [WIDTH-1:0] mem_q [DEPTH];

   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]  count_q, count_d;
   logic             credit_q, credit_d;
   logic             overflow_q, overflow_d;

   logic             push;
   logic             pop;
   logic             full;
   logic             accept;
   logic             drop;

   // Handshake decode: a push into a full buffer is only legal if a pop frees a slot.
   always_comb begin
      push   = valid_i;
      pop    = (count_q != '0) && out_ready;
      full   = (count_q == CntW'(DEPTH));
      accept = push && (!full || pop);
      drop   = push && full && !pop;
   end

   // Next-state for pointers, occupancy, credit return and sticky error.
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      credit_d   = pop;
      overflow_d = overflow_q | drop;

      // Pointers are exactly log2(DEPTH) bits, so increment wraps on its own.
      if (accept) begin
         wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PtrW'(1);
      end

      unique case ({accept, pop})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
   end

   // Control state with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         credit_q   <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         credit_q   <= credit_d;
         overflow_q <= overflow_d;
      end
   end

   // Flit storage write; suppressed during reset so dropped traffic leaves no trace.
   always_ff @(posedge clk) begin
      if (reset && accept) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

   // Head-of-queue outputs, combinational from registered state (no input bypass).
   always_comb begin
      out_valid    = (count_q != '0);
      out_data     = out_valid ? mem_q[rd_ptr_q] : '0;
      count        = count_q;
      credit_o     = credit_q;
      overflow_err = overflow_q;
   end

endmodule

// File: tb/tb_noc_input_buffer.sv
// Bench for noc_input_buffer: directed scenarios plus random traffic, all checked
// cycle by cycle against a queue-based reference model.
module tb_noc_input_buffer;

   localparam int unsigned WIDTH = 16;
   localparam int unsigned DEPTH = 4;

   logic                   clk;
   logic                   reset;
   logic                   valid_i;
   logic [WIDTH-1:0]       data_i;
   logic                   credit_o;
   logic                   out_valid;
   logic [WIDTH-1:0]       out_data;
   logic                   out_ready;
   logic [$clog2(DEPTH):0] count;
   logic                   overflow_err;

   noc_input_buffer #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_dut (
      .clk          (clk),
      .reset        (reset),
      .valid_i      (valid_i),
      .data_i       (data_i),
      .credit_o     (credit_o),
      .out_valid    (out_valid),
      .out_data     (out_data),
      .out_ready    (out_ready),
      .count        (count),
      .overflow_err (overflow_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state
   logic [WIDTH-1:0] mq[$];
   logic             m_credit = 1'b0;
   logic             m_ovf    = 1'b0;

   // Observation logs used by the directed scenarios
   logic [WIDTH-1:0] popped[$];
   int               credit_pulses = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Apply one cycle of stimulus, advance the model, clock, then compare everything.
   task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic r,
                       input logic rn);
      logic [WIDTH-1:0] head;
      int               sz;
      logic             do_pop;
      valid_i   = v;
      data_i    = d;
      out_ready = r;
      reset     = rn;
      if (rn && out_valid && r) popped.push_back(out_data);
      if (!rn) begin
         mq.delete();
         m_credit = 1'b0;
         m_ovf    = 1'b0;
      end else begin
         sz       = mq.size();
         do_pop   = (sz > 0) && r;
         m_credit = do_pop;
         if (do_pop) head = mq.pop_front();
         if (v) begin
            if (sz < DEPTH || do_pop) mq.push_back(d);
            else m_ovf = 1'b1;
         end
      end
      @(posedge clk);
      #1;
      if (credit_o) credit_pulses++;
      check_eq("count", 32'(count), 32'(mq.size()));
      check_eq("out_valid", 32'(out_valid), 32'(mq.size() != 0));
      check_eq("out_data", 32'(out_data), (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
      check_eq("credit_o", 32'(credit_o), 32'(m_credit));
      check_eq("overflow_err", 32'(overflow_err), 32'(m_ovf));
   endtask

   task automatic clear_logs();
      popped.delete();
      credit_pulses = 0;
   endtask

   initial begin
      valid_i   = 1'b0;
      data_i    = '0;
      out_ready = 1'b0;
      reset     = 1'b0;

      // 1: reset held two cycles while upstream presents a flit
      step(1'b1, 16'h1111, 1'b0, 1'b0);
      step(1'b1, 16'h2222, 1'b0, 1'b0);
      check_eq("rst_count", 32'(count), 32'd0);
      check_eq("rst_out_valid", 32'(out_valid), 32'd0);

      // 2: single flit, latency one cycle, credit two cycles after push
      clear_logs();
      step(1'b1, 16'hA5A5, 1'b1, 1'b1);
      check_eq("single_valid", 32'(out_valid), 32'd1);
      check_eq("single_data", 32'(out_data), 32'hA5A5);
      check_eq("single_credit_early", 32'(credit_o), 32'd0);
      step(1'b0, 16'h0, 1'b1, 1'b1);
      check_eq("single_credit", 32'(credit_o), 32'd1);
      check_eq("single_count", 32'(count), 32'd0);
      step(1'b0, 16'h0, 1'b1, 1'b1);
      check_eq("single_credit_once", 32'(credit_o), 32'd0);

      // 3: fill, partial drain, refill across the wrap, full drain
      clear_logs();
      for (int i = 1; i <= 4; i++) step(1'b1, 16'(i), 1'b0, 1'b1);
      check_eq("fill_count", 32'(count), 32'd4);
      step(1'b0, 16'h0, 1'b1, 1'b1);
      step(1'b0, 16'h0, 1'b1, 1'b1);
      step(1'b1, 16'd5, 1'b0, 1'b1);
      step(1'b1, 16'd6, 1'b0, 1'b1);
      for (int i = 0; i < 6; i++) step(1'b0, 16'h0, 1'b1, 1'b1);
      check_eq("order_len", 32'(popped.size()), 32'd6);
      for (int i = 0; i < 6 && i < popped.size(); i++)
         check_eq("order_data", 32'(popped[i]), 32'(i + 1));
      check_eq("order_credits", 32'(credit_pulses), 32'd6);

      // 4: overflow drops the flit and sets a sticky error
      clear_logs();
      for (int i = 0; i < 4; i++) step(1'b1, 16'h100 + 16'(i), 1'b0, 1'b1);
      step(1'b1, 16'hDEAD, 1'b0, 1'b1);
      check_eq("ovf_count", 32'(count), 32'd4);
      check_eq("ovf_flag", 32'(overflow_err), 32'd1);
      for (int i = 0; i < 5; i++) step(1'b0, 16'h0, 1'b1, 1'b1);
      check_eq("ovf_sticky", 32'(overflow_err), 32'd1);
      check_eq("ovf_len", 32'(popped.size()), 32'd4);
      foreach (popped[i]) check_eq("ovf_no_dead", 32'(popped[i] == 16'hDEAD), 32'd0);

      // 5: push and pop together while full
      step(1'b0, 16'h0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b1, 16'h200 + 16'(i), 1'b0, 1'b1);
      step(1'b1, 16'h2FF, 1'b1, 1'b1);
      check_eq("fullpp_count", 32'(count), 32'd4);
      check_eq("fullpp_err", 32'(overflow_err), 32'd0);
      check_eq("fullpp_credit", 32'(credit_o), 32'd1);
      step(1'b0, 16'h0, 1'b0, 1'b1);
      check_eq("fullpp_credit_once", 32'(credit_o), 32'd0);

      // 6: reset with three flits buffered and a pop requested
      step(1'b0, 16'h0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b1, 16'h300 + 16'(i), 1'b0, 1'b1);
      check_eq("midrst_pre", 32'(count), 32'd3);
      step(1'b0, 16'h0, 1'b1, 1'b0);
      check_eq("midrst_count", 32'(count), 32'd0);
      check_eq("midrst_credit", 32'(credit_o), 32'd0);
      step(1'b0, 16'h0, 1'b1, 1'b1);
      check_eq("midrst_no_credit", 32'(credit_o), 32'd0);

      // Random traffic with occasional resets
      for (int i = 0; i < 600; i++) begin
         step(($urandom_range(0, 9) < 6), 16'($urandom), $urandom_range(0, 1) == 1,
              $urandom_range(0, 59) != 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
